// File: rtl/axis_width_conv_pkg.sv
// Shared definitions for the AXI-stream width converters.
package axis_width_conv_pkg;

  // Width of the bit_count conservation output.
  localparam int unsigned BIT_COUNT_W = 16;

  // Bits needed to index the R = n/m narrow slots of one wide word.
  function automatic int unsigned slot_cnt_w(input int unsigned n, input int unsigned m);
    return $clog2(n / m);
  endfunction

endpackage

// File: rtl/axis_width_conv_narrow_wide.sv
// Narrow-to-wide stream packer: M-bit beats packed MSB-first into N-bit words.
// A tfirst beat starts a new word and flushes any partial word zero-padded.
module axis_width_conv_narrow_wide
  import axis_width_conv_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned M = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [M-1:0]           s_axis_tdata,
  input  logic                   s_axis_tfirst,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tnext,
  output logic [N-1:0]           m_axis_tdata,
  output logic                   m_axis_tfirst,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tnext,
  output logic [BIT_COUNT_W-1:0] bit_count
);

  localparam int unsigned R  = N / M;
  localparam int unsigned CW = slot_cnt_w(N, M);

  if (((N % M) != 0) || ((N / M) < 2)) begin : g_param_check
    $error("axis_width_conv_narrow_wide: N must be a multiple of M with N/M >= 2");
  end

  // One narrow beat as seen on the input side.
  typedef struct packed {
    logic         first;
    logic [M-1:0] data;
  } beat_t;

  beat_t                  beat;
  logic [N-1:0]           acc, acc_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic                   afirst, afirst_nxt;
  logic [BIT_COUNT_W-1:0] obits, obits_nxt;
  logic [N-1:0]           odata_nxt;
  logic                   ofirst_nxt, ovalid_nxt;
  logic [BIT_COUNT_W-1:0] bit_count_nxt;
  logic                   emit_complete, emit_flush, emit, out_free, take;

  assign beat = '{first: s_axis_tfirst, data: s_axis_tdata};
  assign s_axis_tnext = take;

  // Accept/emit decision and next-state for accumulator and output register.
  // Slots at or above cnt are kept zero, so a flushed word needs no masking.
  always_comb begin
    emit_complete = (cnt == CW'(R - 1)) && !beat.first;
    emit_flush    = beat.first && (cnt != '0);
    emit          = emit_complete || emit_flush;
    out_free      = !m_axis_tvalid || m_axis_tnext;
    take          = !rst && s_axis_tvalid && (out_free || !emit);

    acc_nxt    = acc;
    cnt_nxt    = cnt;
    afirst_nxt = afirst;
    odata_nxt  = m_axis_tdata;
    ofirst_nxt = m_axis_tfirst;
    obits_nxt  = obits;
    ovalid_nxt = m_axis_tvalid && !m_axis_tnext;

    if (take) begin
      if (emit) begin
        ovalid_nxt = 1'b1;
        ofirst_nxt = afirst;
        acc_nxt    = '0;
        if (emit_complete) begin
          odata_nxt        = acc;
          odata_nxt[M-1:0] = beat.data;
          obits_nxt        = BIT_COUNT_W'(N);
          cnt_nxt          = '0;
          afirst_nxt       = 1'b0;
        end else begin
          odata_nxt            = acc;
          obits_nxt            = BIT_COUNT_W'(cnt) * BIT_COUNT_W'(M);
          acc_nxt[N-1 -: M]    = beat.data;
          cnt_nxt              = CW'(1);
          afirst_nxt           = 1'b1;
        end
      end else begin
        if (cnt == '0) begin
          acc_nxt    = '0;
          afirst_nxt = beat.first;
        end
        for (int unsigned i = 0; i < R; i++) begin
          if (cnt == CW'(i)) begin
            acc_nxt[N-1-i*M -: M] = beat.data;
          end
        end
        cnt_nxt = cnt + CW'(1);
      end
    end

    bit_count_nxt = BIT_COUNT_W'(cnt_nxt) * BIT_COUNT_W'(M)
                  + (ovalid_nxt ? obits_nxt : '0);
  end

  // State registers; reset discards any partial word and the held output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc           <= '0;
      cnt           <= '0;
      afirst        <= 1'b0;
      obits         <= '0;
      m_axis_tdata  <= '0;
      m_axis_tfirst <= 1'b0;
      m_axis_tvalid <= 1'b0;
      bit_count     <= '0;
    end else begin
      acc           <= acc_nxt;
      cnt           <= cnt_nxt;
      afirst        <= afirst_nxt;
      obits         <= obits_nxt;
      m_axis_tdata  <= odata_nxt;
      m_axis_tfirst <= ofirst_nxt;
      m_axis_tvalid <= ovalid_nxt;
      bit_count     <= bit_count_nxt;
    end
  end

endmodule

// File: tb/tb_axis_width_conv_narrow_wide.sv
// Self-checking bench for axis_width_conv_narrow_wide (N=8, M=4) against a
// queue-based packing model.
module tb_axis_width_conv_narrow_wide;

  localparam int unsigned N = 8;
  localparam int unsigned M = 4;
  localparam int unsigned R = N / M;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [M-1:0] s_axis_tdata = '0;
  logic         s_axis_tfirst = 1'b0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tnext;
  logic [N-1:0] m_axis_tdata;
  logic         m_axis_tfirst;
  logic         m_axis_tvalid;
  logic         m_axis_tnext = 1'b0;
  logic [15:0]  bit_count;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    logic [N-1:0] data;
    logic         first;
    int unsigned  bits;
  } word_t;

  word_t        exp_q[$];
  logic [M-1:0] part[$];
  logic         part_first = 1'b0;

  axis_width_conv_narrow_wide #(.N(N), .M(M)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tfirst (s_axis_tfirst),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tnext  (s_axis_tnext),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tfirst (m_axis_tfirst),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tnext  (m_axis_tnext),
    .bit_count     (bit_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Close the partial word: beats MSB-first, unused low slots zero.
  task automatic emit_part();
    word_t w;
    w.data = '0;
    for (int i = 0; i < part.size(); i++) w.data[N-1-i*M -: M] = part[i];
    w.first = part_first;
    w.bits  = part.size() * M;
    exp_q.push_back(w);
    part.delete();
  endtask

  task automatic model_accept(input logic f, input logic [M-1:0] d);
    if (f && part.size() != 0) emit_part();
    if (part.size() == 0) part_first = f;
    part.push_back(d);
    if (part.size() == R) emit_part();
  endtask

  task automatic model_reset();
    part.delete();
    exp_q.delete();
    part_first = 1'b0;
  endtask

  function automatic int unsigned held_bits();
    return part.size() * M + ((exp_q.size() != 0) ? exp_q[0].bits : 0);
  endfunction

  // One cycle: drive at the falling edge, check settled outputs, update model.
  task automatic step(input logic v, input logic f, input logic [M-1:0] d, input logic rdy,
                      output logic took, output logic xfer);
    logic would_emit, exp_tnext;
    word_t w;
    @(negedge clk);
    s_axis_tvalid = v;
    s_axis_tfirst = f;
    s_axis_tdata  = d;
    m_axis_tnext  = rdy;
    #1;
    would_emit = f ? (part.size() != 0) : (part.size() == R - 1);
    exp_tnext  = v && ((exp_q.size() == 0) || rdy || !would_emit);
    check("s_tnext", 32'(s_axis_tnext), 32'(exp_tnext));
    check("m_tvalid", 32'(m_axis_tvalid), 32'(exp_q.size() != 0));
    check("bit_count", 32'(bit_count), held_bits());
    xfer = m_axis_tvalid && m_axis_tnext;
    if (xfer) begin
      if (exp_q.size() == 0) begin
        check("spurious_word", 32'd1, 32'd0);
      end else begin
        w = exp_q.pop_front();
        check("m_tdata", 32'(m_axis_tdata), 32'(w.data));
        check("m_tfirst", 32'(m_axis_tfirst), 32'(w.first));
      end
    end
    took = s_axis_tnext;
    if (took) model_accept(f, d);
  endtask

  task automatic offer(input logic f, input logic [M-1:0] d, input logic rdy);
    logic took, xfer;
    int unsigned n;
    n = 0;
    do begin
      step(1'b1, f, d, rdy, took, xfer);
      n++;
    end while (!took && n < 20);
    if (!took) check("offer_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    logic took, xfer;
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      step(1'b0, 1'b0, '0, 1'b1, took, xfer);
      n++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic took, xfer;
    logic pv, pf;
    logic [M-1:0] pd;
    int unsigned accepted, cycles, in_bits, out_bits, n;

    // Reset held with a beat offered.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      s_axis_tvalid = 1'b1;
      s_axis_tfirst = 1'b1;
      s_axis_tdata  = 4'hA;
      m_axis_tnext  = 1'b1;
      #1;
      check("rst_s_tnext", 32'(s_axis_tnext), 32'd0);
      check("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
      check("rst_m_tdata", 32'(m_axis_tdata), 32'd0);
      check("rst_bit_count", 32'(bit_count), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    s_axis_tvalid = 1'b0;

    // Back-to-back packing: {t,AB} then {-,CD}.
    offer(1'b1, 4'hA, 1'b1);
    offer(1'b0, 4'hB, 1'b1);
    offer(1'b0, 4'hC, 1'b1);
    offer(1'b0, 4'hD, 1'b1);
    drain();

    // Flush of a single-beat word: {t,10} then {t,23}.
    offer(1'b1, 4'h1, 1'b1);
    offer(1'b1, 4'h2, 1'b1);
    offer(1'b0, 4'h3, 1'b1);
    drain();

    // Backpressure: 3 beats accepted, 4th stalls with bit_count 12.
    accepted = 0;
    for (int b = 1; b <= 4; b++) begin
      n = 0;
      do begin
        step(1'b1, 1'b0, 4'(b), 1'b0, took, xfer);
        n++;
      end while (!took && n < 4);
      if (took) accepted++;
    end
    check("bp_accepted", accepted, 32'd3);
    check("bp_bit_count", 32'(bit_count), 32'd12);
    offer(1'b0, 4'h4, 1'b1);
    drain();
    @(negedge clk);
    #1;
    check("bp_bit_count_zero", 32'(bit_count), 32'd0);

    // Asynchronous reset mid-cycle with a held word and cnt=1.
    offer(1'b1, 4'h7, 1'b0);
    offer(1'b0, 4'h8, 1'b0);
    offer(1'b1, 4'h9, 1'b0);
    @(negedge clk);
    s_axis_tvalid = 1'b1;
    s_axis_tfirst = 1'b0;
    s_axis_tdata  = 4'h3;
    m_axis_tnext  = 1'b0;
    #1;
    check("pre_arst_bit_count", 32'(bit_count), 32'd12);
    #1;
    rst = 1'b1;
    #1;
    check("arst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("arst_m_tdata", 32'(m_axis_tdata), 32'd0);
    check("arst_m_tfirst", 32'(m_axis_tfirst), 32'd0);
    check("arst_bit_count", 32'(bit_count), 32'd0);
    check("arst_s_tnext", 32'(s_axis_tnext), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    s_axis_tvalid = 1'b0;
    offer(1'b1, 4'h5, 1'b1);
    offer(1'b0, 4'h6, 1'b1);
    drain();

    // Random traffic: ~1/11 tfirst, random consumer readiness.
    accepted = 0;
    cycles   = 0;
    pv = 1'b0;
    pf = 1'b0;
    pd = '0;
    while (accepted < 1024 && cycles < 20000) begin
      if (!pv) begin
        pv = ($urandom_range(3) != 0);
        pf = ($urandom_range(10) == 0);
        pd = 4'($urandom);
      end
      step(pv, pf, pd, 1'($urandom_range(1)), took, xfer);
      if (took) begin
        accepted++;
        pv = 1'b0;
      end
      cycles++;
    end
    check("random_progress", accepted, 32'd1024);
    drain();

    // Conservation with tfirst disabled, then consumer stalled.
    pulse_reset();
    in_bits  = 0;
    out_bits = 0;
    for (int i = 0; i < 48; i++) begin
      step(1'($urandom_range(1)), 1'b0, 4'($urandom), (i < 40) ? 1'($urandom_range(1)) : 1'b0,
           took, xfer);
      if (took) in_bits += M;
      if (xfer) out_bits += N;
    end
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    #1;
    check("conservation", in_bits, out_bits + 32'(bit_count));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
